// File: rtl/ctrl_sequencer.sv
// Micro-sequencer for the PC/AR/IR/AC/R/DR datapath: fetch, decode, execute.
// Every output is a Moore decode of the state register and the latched opcode.
module ctrl_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] ir,
  input  logic       z,
  output logic [5:0] wen,
  output logic [5:0] inc,
  output logic [5:0] clr,
  output logic [3:0] bus_sel,
  output logic [1:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);

  localparam logic [4:0] S_INIT = 5'd0,  S_IDLE = 5'd1,  S_F1   = 5'd2,  S_F2   = 5'd3,
                         S_F3   = 5'd4,  S_F4   = 5'd5,  S_DEC  = 5'd6,  S_EXEC = 5'd7,
                         S_OPF1 = 5'd8,  S_OPF2 = 5'd9,  S_OPF3 = 5'd10, S_COND = 5'd11,
                         S_JMP1 = 5'd12, S_LD1  = 5'd13, S_LD2  = 5'd14, S_LD3  = 5'd15,
                         S_ST1  = 5'd16, S_ST2  = 5'd17, S_HALT = 5'd18;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  logic [4:0] state, nxt;
  logic [3:0] op;
  logic [2:0] lat;
  logic       mem_wait, lat_done;
  logic       unused_ir;

  assign unused_ir = ^ir[3:0];
  assign mem_wait  = (state == S_F2) || (state == S_OPF2) || (state == S_LD2);
  assign lat_done  = (lat == LAT_LAST);

  always_ff @(posedge Clk) begin
    if (!RST) begin
      state <= S_INIT;
      lat   <= '0;
      op    <= '0;
    end else begin
      state <= nxt;
      // opcode is held so EXEC and the post-operand branches stay pure state decodes
      if (state == S_DEC) op <= ir[7:4];
      lat <= (mem_wait && !lat_done) ? 3'(lat + 3'd1) : 3'd0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_INIT: nxt = S_IDLE;
      S_IDLE: if (start) nxt = S_F1;
      S_F1:   nxt = S_F2;
      S_F2:   if (lat_done) nxt = S_F3;
      S_F3:   nxt = S_F4;
      S_F4:   nxt = S_DEC;
      S_DEC: begin
        if (ir[7:4] == 4'hF)                            nxt = S_HALT;
        else if (ir[7:4] >= 4'h8 && ir[7:4] <= 4'hC)    nxt = S_OPF1;
        else                                            nxt = S_EXEC;
      end
      S_EXEC: nxt = S_F1;
      S_OPF1: nxt = S_OPF2;
      S_OPF2: if (lat_done) nxt = S_OPF3;
      S_OPF3: begin
        case (op)
          4'h8:       nxt = S_JMP1;
          4'h9, 4'hA: nxt = S_COND;
          4'hB:       nxt = S_LD1;
          default:    nxt = S_ST1;
        endcase
      end
      S_COND: nxt = ((op == 4'h9) == z) ? S_JMP1 : S_F1;
      S_JMP1: nxt = S_F1;
      S_LD1:  nxt = S_LD2;
      S_LD2:  if (lat_done) nxt = S_LD3;
      S_LD3:  nxt = S_F1;
      S_ST1:  nxt = S_ST2;
      S_ST2:  nxt = S_F1;
      S_HALT: nxt = S_HALT;
      default: nxt = S_INIT;
    endcase
  end

  always_comb begin
    wen     = '0;
    inc     = '0;
    clr     = '0;
    bus_sel = 4'd0;
    alu_op  = 2'd0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;
    case (state)
      S_INIT:                 clr = 6'h3F;
      S_F1, S_OPF1:           begin bus_sel = 4'd1; wen = 6'h02; end
      S_F2, S_OPF2, S_LD2:    mem_rd = 1'b1;
      S_F3, S_OPF3:           begin bus_sel = 4'd7; wen = 6'h20; inc = 6'h01; end
      S_F4:                   begin bus_sel = 4'd6; wen = 6'h04; end
      S_EXEC: begin
        case (op)
          4'h1: begin bus_sel = 4'd5; wen = 6'h08; end
          4'h2: begin bus_sel = 4'd4; wen = 6'h10; end
          4'h3: begin alu_op = 2'd1; bus_sel = 4'd8; wen = 6'h08; end
          4'h4: begin alu_op = 2'd2; bus_sel = 4'd8; wen = 6'h08; end
          4'h5: inc = 6'h08;
          4'h6: clr = 6'h08;
          default: ;
        endcase
      end
      S_JMP1:                 begin bus_sel = 4'd6; wen = 6'h01; end
      S_LD1, S_ST1:           begin bus_sel = 4'd6; wen = 6'h02; end
      S_LD3:                  begin bus_sel = 4'd7; wen = 6'h08; end
      S_ST2:                  begin bus_sel = 4'd4; mem_wr = 1'b1; end
      S_HALT:                 halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-cycle records (inputs + expected outputs) are queued,
// then applied and compared cycle by cycle against a MEM_LAT=1 or MEM_LAT=3 instance.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic [5:0] wen;
    logic [5:0] inc;
    logic [5:0] clr;
    logic [3:0] bus;
    logic [1:0] alu;
    logic       rd;
    logic       wr;
    logic       halted;
  } out_t;

  typedef struct packed {
    logic       chk;
    logic       rst;
    logic       start;
    logic [7:0] ir;
    logic       z;
    out_t       exp;
  } rec_t;

  typedef struct packed {
    logic [7:0] ir;
    out_t       exec;
  } vec_t;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       z = 1'b0;

  logic [5:0] wen1, inc1, clr1, wen3, inc3, clr3;
  logic [3:0] bus1, bus3;
  logic [1:0] alu1, alu3;
  logic       rd1, wr1, h1, rd3, wr3, h3;
  out_t       o1, o3;

  always #5 Clk = ~Clk;

  ctrl_sequencer #(.MEM_LAT(1)) dut1 (
    .Clk(Clk), .RST(RST), .start(start), .ir(ir), .z(z),
    .wen(wen1), .inc(inc1), .clr(clr1), .bus_sel(bus1), .alu_op(alu1),
    .mem_rd(rd1), .mem_wr(wr1), .halted(h1));

  ctrl_sequencer #(.MEM_LAT(3)) dut3 (
    .Clk(Clk), .RST(RST), .start(start), .ir(ir), .z(z),
    .wen(wen3), .inc(inc3), .clr(clr3), .bus_sel(bus3), .alu_op(alu3),
    .mem_rd(rd3), .mem_wr(wr3), .halted(h3));

  assign o1 = {wen1, inc1, clr1, bus1, alu1, rd1, wr1, h1};
  assign o3 = {wen3, inc3, clr3, bus3, alu3, rd3, wr3, h3};

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];
  logic c_rst = 1'b0, c_start = 1'b0, c_z = 1'b0;
  logic [7:0] c_ir = 8'h00;
  vec_t vecs[9];

  function automatic out_t mk(logic [5:0] w, logic [5:0] i, logic [5:0] c, logic [3:0] b,
                              logic [1:0] a, logic r, logic wr, logic h);
    mk = {w, i, c, b, a, r, wr, h};
  endfunction

  localparam out_t NONE  = 27'd0;
  localparam out_t INIT  = {6'h00, 6'h00, 6'h3F, 4'd0, 2'd0, 3'b000};
  localparam out_t F1    = {6'h02, 6'h00, 6'h00, 4'd1, 2'd0, 3'b000};
  localparam out_t RD    = {6'h00, 6'h00, 6'h00, 4'd0, 2'd0, 3'b100};
  localparam out_t F3    = {6'h20, 6'h01, 6'h00, 4'd7, 2'd0, 3'b000};
  localparam out_t F4    = {6'h04, 6'h00, 6'h00, 4'd6, 2'd0, 3'b000};
  localparam out_t JMP1  = {6'h01, 6'h00, 6'h00, 4'd6, 2'd0, 3'b000};
  localparam out_t ADR1  = {6'h02, 6'h00, 6'h00, 4'd6, 2'd0, 3'b000};
  localparam out_t LD3   = {6'h08, 6'h00, 6'h00, 4'd7, 2'd0, 3'b000};
  localparam out_t ST2   = {6'h00, 6'h00, 6'h00, 4'd4, 2'd0, 3'b010};
  localparam out_t HALT  = {6'h00, 6'h00, 6'h00, 4'd0, 2'd0, 3'b001};

  task automatic push(input out_t e, input logic chk = 1'b1);
    q.push_back({chk, c_rst, c_start, c_ir, c_z, e});
  endtask

  task automatic push_reset();
    c_rst = 1'b0; c_start = 1'b0;
    push(NONE, 1'b0);
    push(INIT); push(INIT);
    c_rst = 1'b1;
    push(INIT);
  endtask

  task automatic push_start();
    c_start = 1'b1; push(NONE); c_start = 1'b0;
  endtask

  task automatic push_opf(input int ml);
    push(F1);
    for (int i = 0; i < ml; i++) push(RD);
    push(F3);
  endtask

  task automatic push_fetch(input logic [7:0] op_ir, input logic op_z, input int ml);
    c_ir = op_ir; c_z = op_z;
    push_opf(ml);
    push(F4);
    push(NONE);
  endtask

  task automatic drain(input bit sel3, input string tag);
    int n = 0;
    while (q.size() > 0) begin
      rec_t r;
      out_t got;
      r = q.pop_front();
      @(posedge Clk); #1;
      RST = r.rst; start = r.start; ir = r.ir; z = r.z;
      @(negedge Clk);
      got = sel3 ? o3 : o1;
      if (r.chk) begin
        checks++;
        if (got !== r.exp) begin
          errors++;
          $display("FAIL %s cyc %0d: got wen=%h inc=%h clr=%h bus=%0d alu=%0d rd=%b wr=%b halt=%b, exp wen=%h inc=%h clr=%h bus=%0d alu=%0d rd=%b wr=%b halt=%b",
                   tag, n, got.wen, got.inc, got.clr, got.bus, got.alu, got.rd, got.wr, got.halted,
                   r.exp.wen, r.exp.inc, r.exp.clr, r.exp.bus, r.exp.alu, r.exp.rd, r.exp.wr, r.exp.halted);
        end
        checks++;
        if (!$onehot0(got.wen) || ((got.wen & got.inc) != 6'h00) || (got.rd && got.wr)) begin
          errors++;
          $display("FAIL %s_invariant cyc %0d: got wen=%h inc=%h rd=%b wr=%b, exp onehot0 wen, disjoint inc, not rd&wr",
                   tag, n, got.wen, got.inc, got.rd, got.wr);
        end
      end
      n++;
    end
  endtask

  initial begin
    vecs[0] = '{8'h00, NONE};
    vecs[1] = '{8'h15, mk(6'h08, 6'h00, 6'h00, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0)};
    vecs[2] = '{8'h2C, mk(6'h10, 6'h00, 6'h00, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0)};
    vecs[3] = '{8'h30, mk(6'h08, 6'h00, 6'h00, 4'd8, 2'd1, 1'b0, 1'b0, 1'b0)};
    vecs[4] = '{8'h4F, mk(6'h08, 6'h00, 6'h00, 4'd8, 2'd2, 1'b0, 1'b0, 1'b0)};
    vecs[5] = '{8'h51, mk(6'h00, 6'h08, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0)};
    vecs[6] = '{8'h60, mk(6'h00, 6'h00, 6'h08, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0)};
    vecs[7] = '{8'hD3, NONE};
    vecs[8] = '{8'hE7, NONE};

    // reset, then the single-cycle ops back to back
    push_reset();
    push(NONE);
    push_start();
    for (int i = 0; i < 9; i++) begin
      push_fetch(vecs[i].ir, 1'b0, 1);
      push(vecs[i].exec);
    end
    push(F1);
    drain(1'b0, "exec_ml1");

    // jumps, conditional branches, load and store with MEM_LAT=1
    push_reset();
    push_start();
    push_fetch(8'h90, 1'b0, 1); push_opf(1); push(NONE);
    push_fetch(8'h90, 1'b1, 1); push_opf(1); push(NONE); push(JMP1);
    push_fetch(8'hA0, 1'b0, 1); push_opf(1); push(NONE); push(JMP1);
    push_fetch(8'hA0, 1'b1, 1); push_opf(1); push(NONE);
    push_fetch(8'h80, 1'b0, 1); push_opf(1); push(JMP1);
    push_fetch(8'hC0, 1'b0, 1); push_opf(1); push(ADR1); push(ST2);
    push_fetch(8'hB0, 1'b0, 1); push_opf(1); push(ADR1); push(RD); push(LD3);
    push(F1);
    drain(1'b0, "branch_ml1");

    // halt ignores start and only reset leaves it
    push_reset();
    push_start();
    push_fetch(8'hF0, 1'b0, 1);
    for (int i = 0; i < 20; i++) begin
      c_start = i[0];
      push(HALT);
    end
    c_start = 1'b0; c_rst = 1'b0;
    push(HALT);
    c_rst = 1'b1;
    push(INIT);
    push(NONE);
    drain(1'b0, "halt");

    // MEM_LAT=3: ADD, then LDM with three read waits in each phase
    push_reset();
    push_start();
    push_fetch(8'h30, 1'b0, 3); push(vecs[3].exec);
    push_fetch(8'hB0, 1'b0, 3); push_opf(3); push(ADR1);
    push(RD); push(RD); push(RD); push(LD3);
    push(F1);
    drain(1'b1, "ldm_ml3");

    // reset in the second read-wait cycle, then a clean fetch
    push_reset();
    push_start();
    c_ir = 8'h15;
    push(F1); push(RD);
    c_rst = 1'b0;
    push(RD);
    c_rst = 1'b1;
    push(INIT);
    push_start();
    push_fetch(8'h15, 1'b0, 3); push(vecs[1].exec);
    push(F1);
    drain(1'b1, "midreset_ml3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
